// File: rtl/alu_seq_exec_if.sv
// Command/result handshake bundle for the sequential execute unit.
// The master drives commands and takes results; the slave is the execute unit.
interface alu_seq_exec_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       alu_control;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             illegal;

   modport master (
      output in_valid, alu_control, src_a, src_b, out_ready,
      input  in_ready, out_valid, result, zero, illegal
   );

   modport slave (
      input  in_valid, alu_control, src_a, src_b, out_ready,
      output in_ready, out_valid, result, zero, illegal
   );
endinterface

// File: rtl/alu_seq_exec.sv
// Multi-cycle execute unit: single-cycle ADD/SUB/logic ops, shifts done one bit
// per cycle through an accumulator, valid/ready handshake on both sides.
module alu_seq_exec #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input logic            clk,
   input logic            rst_n,
   alu_seq_exec_if.slave  alu_io
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_e;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SLL = 3'b001,
      OP_SUB = 3'b010,
      OP_BAD = 3'b011,
      OP_XOR = 3'b100,
      OP_SRL = 3'b101,
      OP_OR  = 3'b110,
      OP_AND = 3'b111
   } op_e;

   state_e             state_q;
   logic               in_ready_q;
   logic               out_valid_q;
   logic [WIDTH-1:0]   result_q;
   logic               zero_q;
   logic               illegal_q;
   logic [WIDTH-1:0]   acc_q;
   logic [SHAMT_W-1:0] cnt_q;
   logic               dir_right_q;

   op_e                op_d;
   logic [SHAMT_W-1:0] shamt_d;
   logic               is_shift_d;
   logic               illegal_cmd_d;
   logic               accept_d;
   logic [WIDTH-1:0]   alu_d;
   logic [WIDTH-1:0]   first_step_d;
   logic [WIDTH-1:0]   acc_step_d;

   // NOTE: every signal assigned in an always_comb gets a default at the top
   // of the block, so no path through the case statement can infer a latch.
   always_comb begin
      op_d          = op_e'(alu_io.alu_control);
      shamt_d       = alu_io.src_b[SHAMT_W-1:0];
      is_shift_d    = (op_d == OP_SLL) || (op_d == OP_SRL);
      illegal_cmd_d = (op_d == OP_BAD);
      accept_d      = alu_io.in_valid && in_ready_q;
      alu_d         = '0;
      case (op_d)
         OP_ADD:  alu_d = alu_io.src_a + alu_io.src_b;
         OP_SUB:  alu_d = alu_io.src_a - alu_io.src_b;
         OP_XOR:  alu_d = alu_io.src_a ^ alu_io.src_b;
         OP_OR:   alu_d = alu_io.src_a | alu_io.src_b;
         OP_AND:  alu_d = alu_io.src_a & alu_io.src_b;
         OP_SLL,
         OP_SRL:  alu_d = alu_io.src_a;   // only reaches the result when shamt == 0
         default: alu_d = '0;
      endcase
      // The first one-bit step happens at acceptance so total latency equals shamt.
      first_step_d = (op_d == OP_SRL) ? (alu_io.src_a >> 1) : (alu_io.src_a << 1);
      acc_step_d   = dir_right_q ? (acc_q >> 1) : (acc_q << 1);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   // NOTE: the accumulator and counter are reset too, so a reset mid-shift
   // leaves no residue that a later command could observe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         illegal_q   <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         dir_right_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept_d) begin
                  in_ready_q <= 1'b0;
                  illegal_q  <= illegal_cmd_d;
                  if (is_shift_d && (shamt_d > SHAMT_W'(1))) begin
                     acc_q       <= first_step_d;
                     cnt_q       <= shamt_d - SHAMT_W'(1);
                     dir_right_q <= (op_d == OP_SRL);
                     state_q     <= S_SHIFT;
                  end else if (is_shift_d && (shamt_d == SHAMT_W'(1))) begin
                     result_q    <= first_step_d;
                     zero_q      <= (first_step_d == '0);
                     out_valid_q <= 1'b1;
                     state_q     <= S_DONE;
                  end else begin
                     // An unsupported code yields result 0 but is not reported as zero.
                     result_q    <= alu_d;
                     zero_q      <= (alu_d == '0) && !illegal_cmd_d;
                     out_valid_q <= 1'b1;
                     state_q     <= S_DONE;
                  end
               end
            end

            S_SHIFT: begin
               acc_q <= acc_step_d;
               cnt_q <= cnt_q - SHAMT_W'(1);
               if (cnt_q == SHAMT_W'(1)) begin
                  result_q    <= acc_step_d;
                  zero_q      <= (acc_step_d == '0);
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end
            end

            S_DONE: begin
               // No bypass: the unit reopens only in the cycle after release.
               if (alu_io.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end

            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign alu_io.in_ready  = in_ready_q;
   assign alu_io.out_valid = out_valid_q;
   assign alu_io.result    = result_q;
   assign alu_io.zero      = zero_q;
   assign alu_io.illegal   = illegal_q;

   a_ready_valid_exclusive : assert property (
      @(posedge clk) disable iff (!rst_n) !(in_ready_q && out_valid_q)
   );

   a_result_held : assert property (
      @(posedge clk) disable iff (!rst_n)
      (out_valid_q && !alu_io.out_ready) |=>
         (out_valid_q && $stable(result_q) && $stable(zero_q) && $stable(illegal_q))
   );

   a_shift_counter_live : assert property (
      @(posedge clk) disable iff (!rst_n)
      (state_q == S_SHIFT) |-> (cnt_q != '0)
   );

endmodule

// File: tb/tb_alu_seq_exec.sv
// Randomized and directed bench for alu_seq_exec, checked every cycle against
// a behavioural model of result value and latency.
module tb_alu_seq_exec;
   localparam int W = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   alu_seq_exec_if #(.WIDTH(W)) bus ();

   alu_seq_exec #(.WIDTH(W), .SHAMT_W(5)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .alu_io (bus.slave)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   int unsigned cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Model of the outstanding command.
   bit          pend     = 1'b0;
   int unsigned valid_at = 0;
   logic [31:0] exp_res  = '0;
   logic        exp_zero = 1'b0;
   logic        exp_ill  = 1'b0;

   function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      int sh;
      sh = int'(b % 32);
      case (op)
         3'd0:    return a + b;
         3'd2:    return a - b;
         3'd1:    return a << sh;
         3'd5:    return a >> sh;
         3'd4:    return a ^ b;
         3'd6:    return a | b;
         3'd7:    return a & b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] op, input logic [31:0] b);
      if ((op == 3'd1 || op == 3'd5) && (b % 32) != 0) return int'(b % 32);
      return 1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_in_ready", 32'(bus.in_ready), 32'd1);
         check("rst_out_valid", 32'(bus.out_valid), 32'd0);
         check("rst_result", bus.result, 32'd0);
         check("rst_zero", 32'(bus.zero), 32'd0);
         check("rst_illegal", 32'(bus.illegal), 32'd0);
      end else if (pend) begin
         check("busy_in_ready", 32'(bus.in_ready), 32'd0);
         if (cyc < valid_at) begin
            check("early_out_valid", 32'(bus.out_valid), 32'd0);
         end else begin
            check("out_valid", 32'(bus.out_valid), 32'd1);
            check("result", bus.result, exp_res);
            check("zero", 32'(bus.zero), 32'(exp_zero));
            check("illegal", 32'(bus.illegal), 32'(exp_ill));
         end
      end else begin
         check("idle_in_ready", 32'(bus.in_ready), 32'd1);
         check("idle_out_valid", 32'(bus.out_valid), 32'd0);
      end
   end

   task automatic pulse_reset();
      @(negedge clk);
      #1 rst_n = 1'b0;
      pend = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic do_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit lit, input logic [31:0] lit_res,
                         input logic lit_zero, input logic lit_ill, input int lit_lat);
      int unsigned acc_cyc;
      bit          seen;
      @(negedge clk);
      bus.in_valid    = 1'b1;
      bus.alu_control = op;
      bus.src_a       = a;
      bus.src_b       = b;
      bus.out_ready   = 1'b0;
      @(posedge clk);
      acc_cyc  = cyc;
      exp_res  = ref_result(op, a, b);
      exp_ill  = (op == 3'd3);
      exp_zero = (exp_res == 32'd0) && !exp_ill;
      valid_at = acc_cyc + ref_latency(op, b);
      pend     = 1'b1;
      seen     = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            seen = 1'b1;
         end else begin
            // Post-acceptance input changes must have no effect.
            bus.in_valid    = 1'($urandom);
            bus.alu_control = 3'($urandom);
            bus.src_a       = $urandom;
            bus.src_b       = $urandom;
         end
      end
      bus.in_valid = 1'b0;
      if (!seen) begin
         n_checks++;
         n_errors++;
         $display("FAIL timeout: out_valid never rose, required within 40 cycles");
         pulse_reset();
         return;
      end
      if (lit) begin
         check("lit_latency", 32'(cyc - acc_cyc), 32'(lit_lat));
         check("lit_result", bus.result, lit_res);
         check("lit_zero", 32'(bus.zero), 32'(lit_zero));
         check("lit_illegal", 32'(bus.illegal), 32'(lit_ill));
      end
      repeat (hold) @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      pend = 1'b0;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic reset_mid_shift();
      int unsigned acc_cyc;
      @(negedge clk);
      bus.in_valid    = 1'b1;
      bus.alu_control = 3'd1;
      bus.src_a       = 32'h0000_0001;
      bus.src_b       = 32'd20;
      @(posedge clk);
      acc_cyc  = cyc;
      exp_res  = 32'h0010_0000;
      exp_ill  = 1'b0;
      exp_zero = 1'b0;
      valid_at = acc_cyc + 20;
      pend     = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      while (cyc < acc_cyc + 10) @(negedge clk);
      #1 rst_n = 1'b0;
      pend = 1'b0;
      #1;
      check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("async_rst_result", bus.result, 32'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      // Compare process now requires idle with no stale out_valid.
      repeat (25) @(negedge clk);
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      bus.in_valid    = 1'b0;
      bus.alu_control = 3'd0;
      bus.src_a       = '0;
      bus.src_b       = '0;
      bus.out_ready   = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;

      check("model_sub_wrap", ref_result(3'd2, 32'd0, 32'd1), 32'hFFFF_FFFF);
      check("model_srl_mod", ref_result(3'd5, 32'h8000_0000, 32'd36), 32'h0800_0000);

      do_cmd(3'd0, 32'h0000_0005, 32'h0000_0003, 0, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 1);
      do_cmd(3'd2, 32'h1234_5678, 32'h1234_5678, 0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1);
      do_cmd(3'd2, 32'h0000_0000, 32'h0000_0001, 1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
      do_cmd(3'd1, 32'h0000_0001, 32'h0000_001F, 0, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 31);
      do_cmd(3'd5, 32'h8000_0000, 32'h0000_0004, 0, 1'b1, 32'h0800_0000, 1'b0, 1'b0, 4);
      do_cmd(3'd5, 32'hDEAD_BEEF, 32'h0000_0020, 0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1);
      do_cmd(3'd1, 32'h8000_0001, 32'h0000_0001, 0, 1'b1, 32'h0000_0002, 1'b0, 1'b0, 1);
      do_cmd(3'd4, 32'hF0F0_F0F0, 32'hFFFF_0000, 5, 1'b1, 32'h0F0F_F0F0, 1'b0, 1'b0, 1);
      do_cmd(3'd3, 32'h0000_0055, 32'h0000_0066, 0, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1);
      do_cmd(3'd6, 32'h0000_0001, 32'h0000_0002, 0, 1'b1, 32'h0000_0003, 1'b0, 1'b0, 1);
      do_cmd(3'd7, 32'hFF00_FF00, 32'h0F0F_0F0F, 2, 1'b1, 32'h0F00_0F00, 1'b0, 1'b0, 1);
      do_cmd(3'd5, 32'h0000_0001, 32'h0000_0001, 0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1);

      reset_mid_shift();

      for (int n = 0; n < 60; n++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
         do_cmd(op, a, b, int'($urandom_range(0, 3)), 1'b0, 32'd0, 1'b0, 1'b0, 0);
      end

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
